// File: rtl/mem_pkg.sv
// mem_pkg -- shared types and constants for the pipelined-latency memory.
//
// Contents:
//   MEM_MAX_LATENCY    : largest supported accept-to-response latency (8).
//   MEM_MAX_DATA_WIDTH : widest word the response struct can carry. Narrower
//                        configurations use the low DATA_WIDTH bits; the
//                        upper bits are held at zero and trimmed by synthesis.
//   mem_rsp_t          : one response (write flag, address-error flag, data).
package mem_pkg;

  localparam int MEM_MAX_LATENCY    = 8;
  localparam int MEM_MAX_DATA_WIDTH = 1024;

  typedef struct packed {
    logic                          write;
    logic                          err;
    logic [MEM_MAX_DATA_WIDTH-1:0] rdata;
  } mem_rsp_t;

endpackage

// File: rtl/mem_rsp_fifo.sv
// mem_rsp_fifo -- response buffer with fall-through when empty.
//
// A response arriving while the buffer is empty and the consumer is ready
// passes straight through in the same cycle; otherwise it is stored and the
// oldest stored entry is presented. The producer never stalls, so the owner
// must guarantee no more than DEPTH responses are ever in flight.
//
// Ports:
//   clk, rst_n         : clock, synchronous active-low reset (empties buffer)
//   in_valid, in_data  : response from the pipeline (no back-pressure)
//   out_valid, out_data: oldest pending response
//   out_ready          : consumer takes out_data on a rising edge with out_valid
module mem_rsp_fifo
  import mem_pkg::*;
#(
  parameter int DEPTH = 3
) (
  input  logic     clk,
  input  logic     rst_n,
  input  logic     in_valid,
  input  mem_rsp_t in_data,
  output logic     out_valid,
  input  logic     out_ready,
  output mem_rsp_t out_data
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  mem_rsp_t        buf_q [DEPTH];
  logic [PW-1:0]   wr_ptr_q;
  logic [PW-1:0]   rd_ptr_q;
  logic [CW-1:0]   count_q;
  logic            empty;
  logic            push;
  logic            pop;

  // Pointers wrap explicitly so DEPTH need not be a power of two.
  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign empty     = (count_q == '0);
  assign out_valid = in_valid || !empty;
  assign out_data  = empty ? in_data : buf_q[rd_ptr_q];
  assign pop       = out_ready && !empty;
  // Only store when the incoming response is not consumed by fall-through.
  assign push      = in_valid && !(empty && out_ready);

  always_ff @(posedge clk) begin
    if (push) begin
      buf_q[wr_ptr_q] <= in_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= ptr_inc(wr_ptr_q);
      if (pop)  rd_ptr_q <= ptr_inc(rd_ptr_q);
      case ({push, pop})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/mem_pipelat.sv
// mem_pipelat -- word memory with fixed access latency and ordered responses.
//
// Handshake: a transfer happens on a rising edge where valid && ready. On the
// request side req_ready depends only on internal state and rst_n, never on
// req_valid. On the response side rsp_valid and rsp_* stay stable from the
// moment rsp_valid rises until the edge where rsp_ready is seen high.
//
// Writes update the selected bytes on the acceptance edge; reads sample the
// array on the acceptance edge. The sampled response travels through a
// LATENCY-deep pipeline that never stalls and lands in mem_rsp_fifo, which
// absorbs back-pressure. Limiting outstanding requests to MAX_OUTST keeps the
// buffer from overflowing.
//
// Build option: define MEM_PIPELAT_RANGE_CHECK_EN to flag req_addr >= DEPTH
// with rsp_err=1, rsp_rdata=0 and no memory update. Without it rsp_err is 0
// and out-of-range addresses must not be presented.
//
// Ports:
//   clk, rst_n                      : clock, synchronous active-low reset
//   req_valid/req_ready             : request handshake
//   req_write, req_addr             : 1=write/0=read, word address
//   req_wdata, req_wstrb            : write data, per-byte enables
//   rsp_valid/rsp_ready             : response handshake
//   rsp_write, rsp_rdata, rsp_err   : response type, read data (0 for writes),
//                                     address error
module mem_pipelat
  import mem_pkg::*;
#(
  parameter  int DATA_WIDTH = 32,
  parameter  int DEPTH      = 1024,
  parameter  int LATENCY    = 2,
  parameter  int MAX_OUTST  = LATENCY + 1,
  localparam int ADDR_WIDTH = $clog2(DEPTH)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic                    req_write,
  input  logic [ADDR_WIDTH-1:0]   req_addr,
  input  logic [DATA_WIDTH-1:0]   req_wdata,
  input  logic [DATA_WIDTH/8-1:0] req_wstrb,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic                    rsp_write,
  output logic [DATA_WIDTH-1:0]   rsp_rdata,
  output logic                    rsp_err
);

  localparam int NB = DATA_WIDTH / 8;
  // Latency outside 1..MEM_MAX_LATENCY is clamped into the supported range.
  localparam int STAGES = (LATENCY < 1) ? 1 :
                          (LATENCY > MEM_MAX_LATENCY) ? MEM_MAX_LATENCY : LATENCY;
  // Two spare bits above what MAX_OUTST needs.
  localparam int CNT_W  = $clog2(MAX_OUTST + 1) + 2;

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic                  pipe_v_q [STAGES];
  mem_rsp_t              pipe_q   [STAGES];
  mem_rsp_t              stage0_d;
  mem_rsp_t              fifo_out;
  logic                  fifo_out_valid;
  logic [CNT_W-1:0]      outst_q;
  logic                  accept;
  logic                  complete;
  logic                  addr_err;
  logic                  unused_rsp_bits;

  assign req_ready = rst_n && (outst_q < CNT_W'(MAX_OUTST));
  assign accept    = req_valid && req_ready;
  assign complete  = rsp_valid && rsp_ready;

`ifdef MEM_PIPELAT_RANGE_CHECK_EN
  assign addr_err = ({1'b0, req_addr} >= (ADDR_WIDTH + 1)'(DEPTH));
`else
  assign addr_err = 1'b0;
`endif

  // Storage: cleared by reset, byte-masked writes on the acceptance edge.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (accept && req_write && !addr_err) begin
      for (int j = 0; j < NB; j++) begin
        if (req_wstrb[j]) mem_q[req_addr][j*8 +: 8] <= req_wdata[j*8 +: 8];
      end
    end
  end

  // Response formed from the array contents before this edge's update, which
  // already include every write accepted earlier.
  always_comb begin
    stage0_d       = '0;
    stage0_d.write = req_write;
    stage0_d.err   = addr_err;
    if (!req_write && !addr_err) begin
      stage0_d.rdata[DATA_WIDTH-1:0] = mem_q[req_addr];
    end
  end

  // Fixed-latency delay line; it advances every cycle regardless of rsp_ready.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < STAGES; i++) begin
        pipe_v_q[i] <= 1'b0;
        pipe_q[i]   <= '0;
      end
    end else begin
      pipe_v_q[0] <= accept;
      pipe_q[0]   <= stage0_d;
      for (int i = 1; i < STAGES; i++) begin
        pipe_v_q[i] <= pipe_v_q[i-1];
        pipe_q[i]   <= pipe_q[i-1];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      outst_q <= '0;
    end else if (accept && !complete) begin
      outst_q <= outst_q + CNT_W'(1);
    end else if (complete && !accept) begin
      outst_q <= outst_q - CNT_W'(1);
    end
  end

  mem_rsp_fifo #(
    .DEPTH (MAX_OUTST)
  ) u_rsp_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (pipe_v_q[STAGES-1]),
    .in_data   (pipe_q[STAGES-1]),
    .out_valid (fifo_out_valid),
    .out_ready (rsp_ready),
    .out_data  (fifo_out)
  );

  // Outputs forced to zero while reset is asserted, before the first reset
  // edge has cleared the pipeline and buffer.
  assign rsp_valid = rst_n && fifo_out_valid;
  assign rsp_write = rst_n && fifo_out.write;
  assign rsp_rdata = rst_n ? fifo_out.rdata[DATA_WIDTH-1:0] : '0;
`ifdef MEM_PIPELAT_RANGE_CHECK_EN
  assign rsp_err   = rst_n && fifo_out.err;
`else
  assign rsp_err   = 1'b0;
`endif

  // Upper struct bits are constant zero for narrow words.
  assign unused_rsp_bits = ^fifo_out;

endmodule

// File: doc/mem_pipelat.md
MEM_PIPELAT -- requirements
Module: mem_pipelat

Interface
REQ-001 Parameter DATA_WIDTH, default 32, word width in bits; SHALL be a multiple of 8.
REQ-002 Parameter DEPTH, default 1024, number of words; need not be a power of 2.
REQ-003 Parameter LATENCY, default 2, accept-to-response cycles; legal range 1..8.
REQ-004 Parameter MAX_OUTST, default LATENCY+1, maximum outstanding requests; SHALL be >= 1.
REQ-005 Localparam ADDR_WIDTH = $clog2(DEPTH).
REQ-006 Clock and reset: clk, rising edge; rst_n synchronous, active-low.
REQ-007 clk  in  1  clock.
REQ-008 rst_n  in  1  synchronous active-low reset.
REQ-009 req_valid  in  1  request present.
REQ-010 req_ready  out  1  request can be accepted.
REQ-011 req_write  in  1  1 = write, 0 = read.
REQ-012 req_addr  in  ADDR_WIDTH  word address.
REQ-013 req_wdata  in  DATA_WIDTH  write data.
REQ-014 req_wstrb  in  DATA_WIDTH/8  byte enables for writes.
REQ-015 rsp_valid  out  1  response present.
REQ-016 rsp_ready  in  1  response consumer ready.
REQ-017 rsp_write  out  1  response belongs to a write.
REQ-018 rsp_rdata  out  DATA_WIDTH  read data; 0 for writes.
REQ-019 rsp_err  out  1  address error (REQ-035).

Function
REQ-020 A request SHALL be accepted on a rising edge where req_valid && req_ready.
REQ-021 A response SHALL complete on a rising edge where rsp_valid && rsp_ready.
REQ-022 Every accepted request SHALL produce exactly one response; responses SHALL be returned in acceptance order.
REQ-023 A write SHALL update the selected bytes (wstrb[j] selects bits j*8+:8) on the acceptance edge; unselected bytes SHALL be unchanged.
REQ-024 Read data SHALL be sampled on the acceptance edge and SHALL reflect every write accepted on an earlier edge.
REQ-025 With rsp_ready held high, the response SHALL be valid exactly LATENCY cycles after acceptance.
REQ-026 A 2-bit-wider outstanding counter SHALL increment on acceptance, decrement on response completion, and stay unchanged when both occur on the same edge.
REQ-027 req_ready SHALL be combinational: (outstanding < MAX_OUTST); it SHALL NOT depend on req_valid.
REQ-028 With MAX_OUTST >= LATENCY+1 and rsp_ready high, throughput SHALL be one request per cycle.
REQ-029 While rsp_ready is low, rsp_valid SHALL stay high and rsp_* SHALL stay stable until completion.
REQ-030 Responses stalled by rsp_ready SHALL be buffered internally; no response SHALL be dropped or duplicated.

Reset
REQ-031 During reset: req_ready=0, rsp_valid=0, rsp_write=0, rsp_rdata=0, rsp_err=0, and the outstanding count SHALL be 0.
REQ-032 Reset SHALL clear all DEPTH words to 0.
REQ-033 Reset asserted mid-operation SHALL discard all in-flight and buffered responses; a request presented in a reset cycle SHALL NOT be accepted.
REQ-034 req_ready SHALL be 1 in the first cycle after rst_n rises.

Configuration
REQ-035 With MEM_PIPELAT_RANGE_CHECK_EN defined, a request with req_addr >= DEPTH SHALL not modify memory and SHALL return rsp_rdata=0, rsp_err=1 at the normal latency.
REQ-036 Without MEM_PIPELAT_RANGE_CHECK_EN, rsp_err SHALL be tied to 0 and req_addr >= DEPTH SHALL be illegal stimulus.

Structure
REQ-037 A shared package mem_pkg SHALL hold the response struct typedef (write, err, rdata) and the MAX LATENCY constant 8.
REQ-038 The response buffer SHALL be a sub-module mem_rsp_fifo: depth MAX_OUTST, fall-through when empty.

Verification
REQ-039 After reset, write addr 5, data 0xDEADBEEF, wstrb 0xF; then read addr 5 -> response data 0xDEADBEEF, rsp_err=0, delivered LATENCY cycles after acceptance.
REQ-040 Write 0x11223344 to addr 7, then write 0xAABBCCDD to addr 7 with wstrb 0x5, then read addr 7 -> 0x11BB33DD.
REQ-041 Send 16 back-to-back reads with rsp_ready=1 -> req_ready stays 1, 16 in-order responses, one per cycle.
REQ-042 Hold rsp_ready=0 and send continuous requests -> exactly MAX_OUTST accepted and req_ready=0; raise rsp_ready -> all responses returned in order with stable data while stalled.
REQ-043 Assert reset with 3 responses outstanding -> rsp_valid=0 next cycle, count 0, and reading addr 5 returns 0.
REQ-044 With MEM_PIPELAT_RANGE_CHECK_EN and DEPTH=1000, write then read addr 1000 -> both responses have rsp_err=1, read data 0, and addr 999 is unaffected.
